// File: rtl/seg7_pkg.sv
// seg7_pkg: shared BCD digit type and 7-segment decode table.
// Provides bcd_t, the active-high gfedcba pattern table SEG7_LUT and
// seg7_decode(), which returns all segments off for values above 9.
package seg7_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG7_LUT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    function automatic logic [6:0] seg7_decode(input bcd_t v);
        return (v > 4'd9) ? 7'h00 : SEG7_LUT[v];
    endfunction

endpackage

// File: rtl/key_edge_sync.sv
// key_edge_sync: 2-flop synchronizer plus registered falling-edge press pulse.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset (sync flops reset to idle 1)
//   key_n - raw asynchronous key, pressed = 0
//   press - one-cycle pulse, high 3 cycles after the raw falling edge
module key_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    // sync[1:0] is the synchronizer, sync[2] holds the previous synchronized level
    logic [2:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '1;
            press <= 1'b0;
        end else begin
            sync  <= {sync[1:0], key_n};
            press <= sync[2] & ~sync[1];
        end
    end

endmodule

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: N-digit BCD up/down counter with multiplexed 7-segment scan driver.
// Ports:
//   CLOCK_50  - sole clock
//   RESET_N   - asynchronous active-low reset
//   KEY_RUN_N - raw run/pause key (pressed = 0), toggles RUNNING
//   KEY_CLR_N - raw clear key (pressed = 0), zeroes count and tick prescaler
//   DOWN      - 0 counts up, 1 counts down, sampled at each tick
//   BLANK_EN  - 1 enables leading-zero blanking
//   SEG       - registered segment drive, bit0 = a .. bit6 = g
//   DIG       - registered one-hot digit enable, DIG[0] = least significant digit
//   BCD       - current count, nibble i = digit i
//   RUNNING   - high while counting is enabled
//   WRAP      - one-cycle pulse on roll-over / roll-under
module bcd_scan_counter
    import seg7_pkg::*;
#(
    parameter int N_DIGITS        = 4,
    parameter int TICK_DIV        = 50_000_000,
    parameter int SCAN_DIV        = 200_000,
    parameter bit SEG_ACTIVE_LOW  = 1'b1,
    parameter bit DIG_ACTIVE_HIGH = 1'b1
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic                    KEY_RUN_N,
    input  logic                    KEY_CLR_N,
    input  logic                    DOWN,
    input  logic                    BLANK_EN,
    output logic [6:0]              SEG,
    output logic [N_DIGITS-1:0]     DIG,
    output logic [4*N_DIGITS-1:0]   BCD,
    output logic                    RUNNING,
    output logic                    WRAP
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic                  run_press;
    logic                  clr_press;
    logic [TW-1:0]         tick_cnt;
    logic                  tick;
    logic [SW-1:0]         scan_cnt;
    logic [IW-1:0]         scan_idx;
    logic [4*N_DIGITS-1:0] bcd_nxt;
    logic [N_DIGITS-1:0]   blank;
    logic                  wrap_all;
    bcd_t                  cur;
    logic [6:0]            seg_on;
    logic [N_DIGITS-1:0]   dig_on;

    key_edge_sync u_run (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .key_n (KEY_RUN_N),
        .press (run_press)
    );

    key_edge_sync u_clr (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .key_n (KEY_CLR_N),
        .press (clr_press)
    );

    assign tick = RUNNING && (tick_cnt == TW'(TICK_DIV - 1));

    // Each digit block owns its carry-in/out and zero-above flags so the
    // ripple chains are separate nets rather than bits of one self-feeding vector.
    for (genvar g = 0; g < N_DIGITS; g++) begin : g_dig
        bcd_t d;
        logic lim;
        logic ci;
        logic co;
        logic za;
        assign d   = BCD[4*g +: 4];
        assign lim = DOWN ? (d == 4'd0) : (d == 4'd9);
        if (g == 0) begin : g_first
            assign ci = 1'b1;
        end else begin : g_rest
            assign ci = g_dig[g-1].co;
        end
        assign co = ci & lim;
        assign bcd_nxt[4*g +: 4] = !ci ? d : lim ? (DOWN ? 4'd9 : 4'd0) : DOWN ? d - 4'd1 : d + 4'd1;
        // za: this digit and every more significant digit are zero
        if (g == N_DIGITS - 1) begin : g_top
            assign za = (d == 4'd0);
        end else begin : g_low
            assign za = (d == 4'd0) && g_dig[g+1].za;
        end
        assign blank[g] = (g > 0) && BLANK_EN && za;
    end

    assign wrap_all = g_dig[N_DIGITS-1].co;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            BCD      <= '0;
            RUNNING  <= 1'b0;
            WRAP     <= 1'b0;
            tick_cnt <= '0;
        end else begin
            WRAP    <= tick && !clr_press && wrap_all;
            RUNNING <= RUNNING ^ run_press;
            if (clr_press) begin
                BCD      <= '0;
                tick_cnt <= '0;
            end else if (tick) begin
                BCD      <= bcd_nxt;
                tick_cnt <= '0;
            end else if (RUNNING) begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IW'(N_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign cur    = BCD[4*scan_idx +: 4];
    assign seg_on = blank[scan_idx] ? 7'h00 : seg7_decode(cur);
    assign dig_on = N_DIGITS'(1) << scan_idx;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            SEG <= SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
            DIG <= DIG_ACTIVE_HIGH ? '0 : '1;
        end else begin
            SEG <= SEG_ACTIVE_LOW ? ~seg_on : seg_on;
            DIG <= DIG_ACTIVE_HIGH ? dig_on : ~dig_on;
        end
    end

endmodule

// File: doc/bcd_scan_counter.md
# bcd_scan_counter

Parametrised N-digit BCD up/down counter with a built-in multiplexed 7-segment scan driver. It replaces the fixed four-digit seconds counter and its binary-to-BCD conversion stage with native per-digit decade counting. It adds run/pause and clear keys, a count direction mode, leading-zero blanking and selectable output polarities. It sits between the board keys and the GPIO header that drives a common-pin multi-digit display.

## Interface
- N_DIGITS, 4: number of displayed digits, legal range 1..8.
- TICK_DIV, 50_000_000: clock cycles per count step, must be ≥2.
- SCAN_DIV, 200_000: clock cycles each digit is enabled, must be ≥2.
- SEG_ACTIVE_LOW, 1: 1 means a lit segment is driven 0.
- DIG_ACTIVE_HIGH, 1: 1 means an enabled digit is driven 1.
- CLOCK_50  in  1  sole clock. One clock; reset is asynchronous and active-low.
- RESET_N  in  1  asynchronous active-low reset.
- KEY_RUN_N  in  1  raw run/pause key, asynchronous, pressed = 0.
- KEY_CLR_N  in  1  raw clear key, asynchronous, pressed = 0.
- DOWN  in  1  level input: 0 counts up, 1 counts down. Sampled at each tick.
- BLANK_EN  in  1  level input: 1 enables leading-zero blanking.
- SEG  out  7  segment drive, bit0 = a through bit6 = g.
- DIG  out  N_DIGITS  digit enables, one-hot when active. DIG[0] is the least significant digit.
- BCD  out  4*N_DIGITS  current count. Nibble i holds digit i.
- RUNNING  out  1  high while counting is enabled.
- WRAP  out  1  one-cycle pulse on roll-over or roll-under.

## Operation
- **Reset values.** Count = 0, RUNNING = 0, WRAP = 0, both prescalers = 0, scan index = 0. Key sync flops are set to 1 (idle). DIG is all inactive. SEG is all segments off.
- **Key handling.** Each key passes through a 2-flop synchronizer followed by falling-edge detection, which produces a 1-cycle press pulse. There is no debounce; upstream or the bench provides clean edges.
- **Run press.** Toggles RUNNING.
- **Clear press.** Sets the count to 0 and the tick prescaler to 0. RUNNING is unchanged.
- **Tick prescaler.** Counts 0..TICK_DIV-1 only while RUNNING is high. A tick fires in the cycle the prescaler equals TICK_DIV-1, and the prescaler then returns to 0. While paused, the prescaler holds its value.
- **Counting up.** On a tick, digit 0 increments. A digit at 9 becomes 0 and carries into the next digit. When all digits are 9, the count becomes all 0 and WRAP pulses.
- **Counting down.** On a tick, digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit. When all digits are 0, the count becomes all 9 and WRAP pulses.
- **Simultaneous events.**
  - Clear and tick in the same cycle: clear wins, and neither the increment nor WRAP occurs.
  - Run press and tick in the same cycle: the tick is applied, then RUNNING toggles.
  - A DOWN change takes effect at the next tick.
- **Scan prescaler.** Free-running over 0..SCAN_DIV-1, independent of RUNNING. At SCAN_DIV-1 the scan index advances, wrapping from N_DIGITS-1 to 0.
- **Digit drive.** DIG enables only the digit at the scan index.
- **Segment decode (active-high gfedcba).** 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Inverted when SEG_ACTIVE_LOW = 1.
- **Blanking.** When BLANK_EN = 1, digit i (i > 0) is blank if it and every higher digit are 0. Digit 0 is never blanked. A blanked digit keeps its DIG slot, so duty cycle is unchanged, but SEG shows all segments off.
- **Illegal nibbles.** Cannot occur. Decode defaults to all segments off.

## Timing
- Raw key falling edge to press pulse: 3 cycles. The action is visible at the outputs on the 4th cycle.
- Tick to updated BCD and WRAP: both are registered and appear together on the cycle after the tick.
- SEG and DIG are registered. They update 1 cycle after a scan index change or a BCD change. There are no combinational paths from inputs to outputs.
- Each digit is enabled for exactly SCAN_DIV cycles. The full frame is N_DIGITS*SCAN_DIV cycles.
- Reset asserted mid-count takes effect immediately (asynchronous). After release, the first tick occurs TICK_DIV cycles after RUNNING rises.

## Structure
- **Package `seg7_pkg`:**
  - typedef `bcd_t` (logic [3:0]);
  - constant array `SEG7_LUT` [0:9] holding the active-high patterns;
  - function `seg7_decode(bcd_t)` returning 7 bits, all off when the value is >9.
- **Sub-module `key_edge_sync`:** 2-flop sync plus falling-edge pulse, instantiated twice.
- Per-digit carry/borrow is a generate loop inside `bcd_scan_counter`, not a separate module.

## Test plan
All scenarios use N_DIGITS=4, TICK_DIV=4, SCAN_DIV=3, SEG_ACTIVE_LOW=1, DIG_ACTIVE_HIGH=1.
- **Reset.** Pulse RESET_N low → BCD=0000, RUNNING=0, WRAP=0, DIG=0000, SEG=7F.
- **Count up with carry.** Press run with DOWN=0, then wait 40 cycles → BCD=0x0010, RUNNING=1, no WRAP.
- **Roll-under.** Set DOWN=1 from 0000 and press run → after the first tick BCD=0x9999, with WRAP high for exactly 1 cycle.
- **Clear/tick collision.** Press clear so the pulse lands on the tick cycle, with count 0x0007 → BCD=0x0000 and WRAP=0. The next increment happens 4 cycles later.
- **Scan and blanking.** Count at 0x0042 with BLANK_EN=1 → DIG cycles 0001, 0010, 0100, 1000, each for 3 cycles. SEG shows 24, 19, 7F, 7F respectively. With BLANK_EN=0, digits 2 and 3 show 40.
- **Asynchronous reset mid-count.** Assert RESET_N between clock edges while running at 0x0123 → outputs reach reset values before the next edge, and counting stays stopped after release.
